// File: rtl/img_out_streamer_pkg.sv
// img_out_streamer shared widths, pixel limit and FSM states.
// clamp_pix limits a requested pixel count to the image size.
package img_pkg;

   localparam int ADDR_W = 13;
   localparam int PIX_W = 8;
   localparam logic [ADDR_W-1:0] MAX_PIX = 13'd2500;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_e;

   function automatic logic [ADDR_W-1:0] clamp_pix(
      input logic [ADDR_W-1:0] n
   );
      return (n > MAX_PIX) ? MAX_PIX : n;
   endfunction

endpackage

// File: rtl/img_out_streamer_if.sv
// Byte stream handshake leaving img_out_streamer.
// master drives data/valid, slave answers with ready.
interface img_out_streamer_if;
   import img_pkg::*;

   logic [PIX_W-1:0] tx_data;
   logic             tx_valid;
   logic             tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );

endinterface

// File: rtl/img_out_streamer_fifo.sv
// stream_fifo2: two-entry pixel FIFO between RAM read data and tx.
// dout is forced to zero while empty so idle tx_data reads as 0.
module stream_fifo2
   import img_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [PIX_W-1:0] din_i,
   input  logic             pop_i,
   output logic [PIX_W-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [1:0]       occ_o
);

   logic [PIX_W-1:0] mem_q [2];
   logic             wp_q, wp_d;
   logic             rp_q, rp_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == 2'd2);
   assign empty_o = (cnt_q == 2'd0);
   assign occ_o   = cnt_q;
   assign dout_o  = empty_o ? '0 : mem_q[rp_q];
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   always_comb begin
      wp_d  = wp_q;
      rp_d  = rp_q;
      cnt_d = cnt_q;
      if (do_push) wp_d = ~wp_q;
      if (do_pop)  rp_d = ~rp_q;
      unique case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= din_i;
   end

endmodule

// File: rtl/img_out_streamer.sv
// img_out_streamer: reads N pixels from RAM port B in address order
// and streams them out over a valid/ready byte interface.
module img_out_streamer
   import img_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] num_pix,
   output logic [ADDR_W-1:0] ram_addr_b,
   output logic              ram_we_b,
   output logic [PIX_W-1:0]  ram_data_b,
   input  logic [PIX_W-1:0]  ram_q_b,
   img_out_streamer_if.master tx,
   output logic              busy,
   output logic              done
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] n_q, n_d;
   logic [ADDR_W-1:0] iss_q, iss_d;
   logic [ADDR_W-1:0] xfr_q, xfr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              fly_q, fly_d;
   logic [ADDR_W-1:0] n_clamp;
   logic              pop, issue, last;
   logic              f_full, f_empty;
   logic [1:0]        f_occ;
   logic [2:0]        lvl;
   logic [PIX_W-1:0]  f_dout;

   stream_fifo2 u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fly_q),
      .din_i   (ram_q_b),
      .pop_i   (pop),
      .dout_o  (f_dout),
      .full_o  (f_full),
      .empty_o (f_empty),
      .occ_o   (f_occ)
   );

   assign tx.tx_valid = ~f_empty;
   assign tx.tx_data  = f_dout;
   assign pop         = ~f_empty & tx.tx_ready;

   // Slots still claimed after this edge; a pop frees one in time.
   assign lvl = {1'b0, f_occ} + {2'b00, fly_q} - {2'b00, pop};

   assign issue = (state_q == S_RUN) && (iss_q < n_q)
                  && (lvl < 3'd2) && (!f_full || pop);
   assign last  = pop && (xfr_q == n_q - ADDR_W'(1));

   assign n_clamp    = clamp_pix(num_pix);
   assign ram_addr_b = addr_q;
   assign ram_we_b   = 1'b0;
   assign ram_data_b = '0;
   assign busy       = (state_q != S_IDLE) | (start & rst_n);
   assign done       = (state_q == S_FIN);

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      iss_d   = iss_q;
      xfr_d   = xfr_q;
      addr_d  = addr_q;
      fly_d   = issue;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d     = n_clamp;
               iss_d   = '0;
               xfr_d   = '0;
               state_d = (n_clamp == '0) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (issue) begin
               addr_d = iss_q;
               iss_d  = iss_q + ADDR_W'(1);
            end
            if (pop)  xfr_d   = xfr_q + ADDR_W'(1);
            if (last) state_d = S_FIN;
         end
         S_FIN: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         n_q     <= '0;
         iss_q   <= '0;
         xfr_q   <= '0;
         addr_q  <= '0;
         fly_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         iss_q   <= iss_d;
         xfr_q   <= xfr_d;
         addr_q  <= addr_d;
         fly_q   <= fly_d;
      end
   end

endmodule

// File: doc/img_out_streamer.md
IMG_OUT_STREAMER -- requirements
Module: img_out_streamer

Interface
REQ-001 clk  input  1  single system clock; all logic SHALL be on its rising edge.
REQ-002 rst_n  input  1  reset; SHALL be synchronous and active-low.
REQ-003 start  input  1  single-cycle request to stream the output image; sampled only in IDLE.
REQ-004 num_pix  input  13  pixel count to stream; sampled with start.
REQ-005 ram_addr_b  output  13  registered read address to output-image RAM port B.
REQ-006 ram_we_b  output  1  SHALL be constant 0; the block never writes.
REQ-007 ram_data_b  output  8  SHALL be constant 0.
REQ-008 ram_q_b  input  8  port B read data, valid one clock after the address edge.
REQ-009 tx_data  output  8  streamed pixel byte.
REQ-010 tx_valid  output  1  tx_data holds a valid byte.
REQ-011 tx_ready  input  1  downstream accepts the byte; a transfer occurs on a cycle with tx_valid and tx_ready both high.
REQ-012 busy  output  1  high from start acceptance until the done cycle, inclusive.
REQ-013 done  output  1  single-cycle pulse after the last transfer.

Function
REQ-014 States SHALL be IDLE, RUN and FIN.
- IDLE -> RUN on start with num_pix != 0.
- IDLE -> FIN on start with num_pix == 0.
- RUN -> FIN on the cycle the final byte transfers.
- FIN -> IDLE unconditionally after one cycle; done = 1 only in FIN.
REQ-015 A num_pix value greater than 2500 SHALL be clamped to 2500 at sampling.
REQ-016 Addresses SHALL be issued in order 0, 1, ..., N-1, where N is the clamped count, with no wrap and no reissue; after the last issue ram_addr_b SHALL hold N-1.
REQ-017 Read data SHALL land in a 2-entry FIFO; a read SHALL be issued only when FIFO occupancy plus reads in flight is less than 2, so data is never dropped.
REQ-018 The first tx_valid SHALL rise 2 clocks after the start-sampling edge.
REQ-019 With tx_ready held high, transfers SHALL sustain 1 byte per clock.
REQ-020 While tx_valid = 1 and tx_ready = 0, tx_data and tx_valid SHALL remain stable.
REQ-021 tx_valid SHALL never assert for more than N bytes per start.
REQ-022 start SHALL be ignored while busy = 1; there is no queueing.
REQ-023 done SHALL assert 1 clock after the final transfer, and the block SHALL accept a new start on the cycle after done.
REQ-024 Internal pixel counters SHALL be 13 bits and SHALL not overflow for N up to 2500.

Reset
REQ-025 While rst_n = 0, on each clock the block SHALL go to IDLE and clear FIFO, counters and in-flight flags.
REQ-026 Reset values: tx_valid = 0, tx_data = 0, ram_addr_b = 0, busy = 0, done = 0.
REQ-027 A reset mid-stream SHALL abort with no done pulse and no further tx_valid; the next start SHALL restart from address 0.

Structure
REQ-028 Package img_pkg SHALL hold ADDR_W = 13, PIX_W = 8 and MAX_PIX = 2500, plus the state enumeration typedef.
REQ-029 The 2-entry FIFO SHALL be a separate sub-module, stream_fifo2, with push, pop, full, empty and occupancy outputs.

Verification
REQ-030 RAM[k] = k for k = 0..15, start with num_pix = 16, tx_ready = 1 -> tx_data 0..15 on 16 consecutive cycles, first byte 2 clocks after start, done 1 clock after byte 15.
REQ-031 Same image with tx_ready toggling 1,0,0,1,... -> each byte held stable while not ready, sequence 0..15 exact, no duplicates or drops.
REQ-032 start with num_pix = 0 -> no tx_valid, busy for 2 cycles, done on the cycle after start.
REQ-033 start with num_pix = 3000 -> exactly 2500 transfers, maximum address 2499, a single done pulse.
REQ-034 rst_n low for 1 cycle after byte 5 of 16 -> all outputs 0 on the next cycle, no done; a new start streams from 0.
REQ-035 start pulsed again mid-stream -> ignored; exactly 16 bytes and one done.
